iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 146 ++++++++++++++
 tb/tb_iter_div.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// iter_div: iterative restoring radix-2 divider, signed or unsigned.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        launch a divide (sampled only in IDLE)
//   signed_op    1 = signed divide, 0 = unsigned (sampled with start)
//   annul        abandon the current operation / block a launch
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   quotient     registered quotient, updated on entry to FIN
//   remainder    registered remainder, updated on entry to FIN
//   done         one-cycle pulse while in FIN
//   busy         high in DIV0 and RUN (stall request)
//   div_by_zero  qualifies done: divisor was zero
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// DIV0  | zero divisor, one cycle to produce the flagged result
// RUN   | one restoring step per cycle, DATA_W steps
// FIN   | results valid, done pulse, back to IDLE next edge

module iter_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done,
    output logic              busy,
    output logic              div_by_zero
);

    typedef enum logic [1:0] {IDLE, DIV0, RUN, FIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_q;     // dividend magnitude shifting out, quotient bits shifting in
    logic [DATA_W-1:0] acc_r;     // partial remainder
    logic [DATA_W-1:0] dvsr_mag;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] dvd_mag_in;
    logic [DATA_W-1:0] dvsr_mag_in;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              fits;
    logic [DATA_W-1:0] step_q;
    logic [DATA_W-1:0] step_r;
    logic [DATA_W-1:0] fin_q;
    logic [DATA_W-1:0] fin_r;
    logic              last_step;

    always_comb begin
        dvd_mag_in  = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
        dvsr_mag_in = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;

        trial  = {acc_r, acc_q[DATA_W-1]};
        diff   = trial - {1'b0, dvsr_mag};
        fits   = ~diff[DATA_W];
        // when the trial does not fit it is below the divisor, so its top bit is 0
        step_r = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        step_q = {acc_q[DATA_W-2:0], fits};

        fin_q     = neg_q ? -step_q : step_q;
        fin_r     = neg_r ? -step_r : step_r;
        last_step = (cnt == CNT_W'(DATA_W-1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !annul) state_nxt = (divisor == '0) ? DIV0 : RUN;
            DIV0: state_nxt = annul ? IDLE : FIN;
            RUN: begin
                if (annul)          state_nxt = IDLE;
                else if (last_step) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_q       <= '0;
            acc_r       <= '0;
            dvsr_mag    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            // outputs registered from the next state so they line up with it
            done  <= (state_nxt == FIN);
            busy  <= (state_nxt == DIV0) || (state_nxt == RUN);

            case (state)
                IDLE: begin
                    if (state_nxt != IDLE) begin
                        acc_q    <= dvd_mag_in;
                        acc_r    <= '0;
                        dvsr_mag <= dvsr_mag_in;
                        neg_q    <= signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        neg_r    <= signed_op & dividend[DATA_W-1];
                        cnt      <= '0;
                    end
                end
                DIV0: begin
                    if (state_nxt == FIN) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= step_q;
                    acc_r <= step_r;
                    cnt   <= cnt + CNT_W'(1);
                    if (state_nxt == FIN) begin
                        quotient    <= fin_q;
                        remainder   <= fin_r;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: scoreboard bench for iter_div (32-bit instance plus an 8-bit instance).

module tb_iter_div;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, signed_op, annul;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        done, busy, div_by_zero;

    logic        s8_start, s8_signed_op, s8_annul;
    logic [7:0]  s8_dividend, s8_divisor, s8_quotient, s8_remainder;
    logic        s8_done, s8_busy, s8_div_by_zero;

    iter_div u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op), .annul(annul),
        .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
        .done(done), .busy(busy), .div_by_zero(div_by_zero)
    );

    iter_div #(.DATA_W(8), .CNT_W(4)) u_div8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .signed_op(s8_signed_op), .annul(s8_annul),
        .dividend(s8_dividend), .divisor(s8_divisor), .quotient(s8_quotient),
        .remainder(s8_remainder), .done(s8_done), .busy(s8_busy), .div_by_zero(s8_div_by_zero)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_q, last_r;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", div_by_zero, mon_e.dz);
                last_q = mon_e.q;
                last_r = mon_e.r;
            end
        end
    end

    // called at a negedge, returns at a negedge with the DUT back in IDLE
    task automatic run_div(input logic so, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input int lat);
        int n;
        int bcnt;
        signed_op = so;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        sb.push_back('{q: eq, r: er, dz: edz});
        @(posedge clk);
        @(negedge clk);
        bcnt = busy ? 1 : 0;
        // scrambled operands and a held start must be ignored once launched
        dividend  = ~a;
        divisor   = b + 32'd5;
        signed_op = ~so;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 2;
        if (busy) bcnt++;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (busy) bcnt++;
        end
        check("latency", n, lat);
        check("busy_cycles", bcnt, lat - 1);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
    endtask

    function automatic void model(input logic so, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa, sb_v;
        sa   = a;
        sb_v = b;
        if (so) begin
            q = sa / sb_v;
            r = sa % sb_v;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic        rso;
        int          n;

        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        dividend = '0; divisor = '0;
        s8_start = 1'b0; s8_signed_op = 1'b0; s8_annul = 1'b0;
        s8_dividend = '0; s8_divisor = '0;
        last_q = '0; last_r = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);

        rst_n = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_div(1'b0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rso = i[0];
            if (i >= 3) rb = rb >> 20;
            if (rb == 0) rb = 32'd3;
            if (rso && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd5;
            model(rso, ra, rb, mq, mr);
            run_div(rso, ra, rb, mq, mr, 1'b0, 33);
        end

        // annul mid-RUN: no done, previous results held
        dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy", busy, 0);
        check("annul_q_held", quotient, last_q);
        check("annul_r_held", remainder, last_r);
        repeat (40) @(negedge clk);
        run_div(1'b0, 32'd5, 32'd5, 32'd1, 32'd0, 1'b0, 33);

        // start together with annul in IDLE launches nothing
        dividend = 32'd9; divisor = 32'd2; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check("annul_blocks_start", busy, 0);
        repeat (5) @(negedge clk);

        // reset mid-RUN
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // 8-bit instance
        s8_dividend = 8'hFF; s8_divisor = 8'h10; s8_signed_op = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        n = 1;
        while (s8_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("w8_latency", n, 9);
        check("w8_quotient", s8_quotient, 8'h0F);
        check("w8_remainder", s8_remainder, 8'h0F);
        check("w8_dz", s8_div_by_zero, 0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
